xnort_pulse_seq: RTL and testbench



---
 rtl/xnort_seq_pkg.sv | 28 ++
 rtl/xnort_seq_delay_ctr.sv | 24 ++
 rtl/xnort_pulse_seq.sv | 145 ++++++++++++++
 tb/tb_xnort_pulse_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xnort_seq_pkg.sv
// Shared types and constants for the XNORT pulse sequencer.
// The optional q_i observation path is enabled by defining XNORT_SEQ_CHECK_EN.
package xnort_seq_pkg;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_SEND_A,
        ST_GAP_AB,
        ST_SEND_B,
        ST_GAP_DC,
        ST_SEND_CLK,
        ST_WATCH,
        ST_RESP
    } seq_state_t;

    localparam int DEF_SEP_AB       = 2;
    localparam int DEF_SEP_DATA_CLK = 2;
    localparam int DEF_SEP_CLK_DATA = 3;
    localparam int DEF_Q_TIMEOUT    = 4;
    localparam int DEF_INIT_CYCLES  = 8;

    // Bits needed to hold any value in 0..max_val, never less than one.
    function automatic int ctr_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/xnort_seq_delay_ctr.sv
// Loadable down-counter; done is high while the count sits at zero.
// Used for every timed FSM state of the XNORT pulse sequencer.
module xnort_seq_delay_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/xnort_pulse_seq.sv
// Pulse sequencer driving one toggle-encoded XNORT cell from a request stream.
// Define XNORT_SEQ_CHECK_EN to observe q_i and report real results and errors.
module xnort_pulse_seq
    import xnort_seq_pkg::*;
#(
    parameter int SEP_AB       = DEF_SEP_AB,
    parameter int SEP_DATA_CLK = DEF_SEP_DATA_CLK,
    parameter int SEP_CLK_DATA = DEF_SEP_CLK_DATA,
    parameter int Q_TIMEOUT    = DEF_Q_TIMEOUT,
    parameter int INIT_CYCLES  = DEF_INIT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_a,
    input  logic       req_b,
    output logic       a_o,
    output logic       b_o,
    output logic       clk_o,
    input  logic       q_i,
    output logic       rsp_valid,
    output logic       rsp_q,
    output logic       rsp_error,
    output seq_state_t dbg_state
);

    if (Q_TIMEOUT < SEP_CLK_DATA || SEP_AB < 1 || SEP_DATA_CLK < 1 ||
        SEP_CLK_DATA < 1 || INIT_CYCLES < 1) begin : g_bad_params
        $error("xnort_pulse_seq: separation parameters out of range");
    end

    localparam int MAX_A = (INIT_CYCLES > Q_TIMEOUT) ? INIT_CYCLES : Q_TIMEOUT;
    localparam int MAX_B = (SEP_AB > SEP_DATA_CLK) ? SEP_AB : SEP_DATA_CLK;
    localparam int CW    = ctr_width((MAX_A > MAX_B) ? MAX_A : MAX_B);

    // Load values are duration-1: the counter is loaded on entry and the state
    // is left on the cycle it reads zero.
    localparam logic [CW-1:0] LD_INIT   = CW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] LD_GAP_AB = CW'((SEP_AB > 1) ? SEP_AB - 2 : 0);
    localparam logic [CW-1:0] LD_GAP_DC = CW'((SEP_DATA_CLK > 1) ? SEP_DATA_CLK - 2 : 0);
    localparam logic [CW-1:0] LD_WATCH  = CW'(Q_TIMEOUT - 1);

    seq_state_t    state, next_state;
    logic          op_b;
    logic          expected;
    logic          ctr_load;
    logic [CW-1:0] ctr_val;
    logic          ctr_done;

    xnort_seq_delay_ctr #(.W(CW)) u_delay_ctr (
        .clk      (clk),
        .load     (ctr_load),
        .load_val (ctr_val),
        .done     (ctr_done)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_INIT:     if (ctr_done) next_state = ST_IDLE;
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_a)      next_state = ST_SEND_A;
                    else if (req_b) next_state = ST_SEND_B;
                    else            next_state = ST_SEND_CLK;
                end
            end
            ST_SEND_A: begin
                if (op_b) next_state = (SEP_AB > 1) ? ST_GAP_AB : ST_SEND_B;
                else      next_state = (SEP_DATA_CLK > 1) ? ST_GAP_DC : ST_SEND_CLK;
            end
            ST_GAP_AB:   if (ctr_done) next_state = ST_SEND_B;
            ST_SEND_B:   next_state = (SEP_DATA_CLK > 1) ? ST_GAP_DC : ST_SEND_CLK;
            ST_GAP_DC:   if (ctr_done) next_state = ST_SEND_CLK;
            ST_SEND_CLK: next_state = ST_WATCH;
            ST_WATCH:    if (ctr_done) next_state = ST_RESP;
            ST_RESP:     next_state = ST_IDLE;
            default:     next_state = ST_INIT;
        endcase
    end

    always_comb begin
        ctr_val = '0;
        case (next_state)
            ST_GAP_AB: ctr_val = LD_GAP_AB;
            ST_GAP_DC: ctr_val = LD_GAP_DC;
            ST_WATCH:  ctr_val = LD_WATCH;
            default:   ctr_val = '0;
        endcase
        if (rst) ctr_val = LD_INIT;
    end

    assign ctr_load = rst | (next_state != state);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            a_o      <= 1'b0;
            b_o      <= 1'b0;
            clk_o    <= 1'b0;
            op_b     <= 1'b0;
            expected <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && req_valid) begin
                op_b     <= req_b;
                expected <= ~(req_a ^ req_b);
            end
            if (state == ST_SEND_A)   a_o   <= ~a_o;
            if (state == ST_SEND_B)   b_o   <= ~b_o;
            if (state == ST_SEND_CLK) clk_o <= ~clk_o;
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign dbg_state = state;

`ifdef XNORT_SEQ_CHECK_EN
    logic q_prev;
    logic q_seen;

    // q_prev follows q_i even in reset so release never looks like a toggle.
    always_ff @(posedge clk) begin
        q_prev <= q_i;
        if (rst) begin
            q_seen <= 1'b0;
        end else if (state == ST_SEND_CLK) begin
            q_seen <= 1'b0;
        end else if (state == ST_WATCH && (q_i != q_prev)) begin
            q_seen <= 1'b1;
        end
    end

    assign rsp_q     = rsp_valid & q_seen;
    assign rsp_error = rsp_valid & (q_seen != expected);
`else
    logic unused_q;
    assign unused_q  = q_i;
    assign rsp_q     = rsp_valid & expected;
    assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_xnort_pulse_seq.sv
// Scoreboard bench for xnort_pulse_seq with a behavioural XNORT cell model.
// Expectations follow XNORT_SEQ_CHECK_EN the same way the design build does.
module tb_xnort_pulse_seq;
    import xnort_seq_pkg::*;

    localparam int SEP_AB       = 2;
    localparam int SEP_DATA_CLK = 2;
    localparam int SEP_CLK_DATA = 3;
    localparam int Q_TIMEOUT    = 4;
    localparam int INIT_CYCLES  = 8;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_NEVER  = 1;
    localparam int MODE_DOUBLE = 2;

`ifdef XNORT_SEQ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int   a_t;
        int   b_t;
        int   clk_t;
        int   rsp_t;
        logic q;
        logic err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_a = 1'b0;
    logic req_b = 1'b0;
    logic q_model = 1'b0;
    logic q_extra = 1'b0;
    logic q_i;
    logic req_ready, a_o, b_o, clk_o, rsp_valid, rsp_q, rsp_error;
    seq_state_t dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cell_mode = MODE_NORMAL;
    exp_t exp_q[$];

    assign q_i = q_model ^ q_extra;

    always #5 clk = ~clk;

    xnort_pulse_seq #(
        .SEP_AB(SEP_AB), .SEP_DATA_CLK(SEP_DATA_CLK), .SEP_CLK_DATA(SEP_CLK_DATA),
        .Q_TIMEOUT(Q_TIMEOUT), .INIT_CYCLES(INIT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .a_o(a_o), .b_o(b_o), .clk_o(clk_o),
        .q_i(q_i), .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_error(rsp_error),
        .dbg_state(dbg_state)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Edge offsets from the accepting edge, taken straight from the pulse rules.
    function automatic exp_t model(input logic a, input logic b, input int mode);
        exp_t e;
        int   last_data;
        logic x;
        x = ~(a ^ b);
        e.a_t = a ? 1 : -1;
        e.b_t = b ? (a ? 1 + SEP_AB : 1) : -1;
        last_data = b ? e.b_t : (a ? e.a_t : 0);
        e.clk_t = (a | b) ? last_data + SEP_DATA_CLK : 1;
        e.rsp_t = e.clk_t + Q_TIMEOUT;
        if (CHK) begin
            e.q   = x & (mode != MODE_NEVER);
            e.err = (e.q != x);
        end else begin
            e.q   = x;
            e.err = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Cell model: on a clk pulse, q toggles when the a and b pulse parities agree.
    logic ma = 1'b0, mb = 1'b0, mc = 1'b0, rst_prev = 1'b1;
    logic par_a = 1'b0, par_b = 1'b0, dbl_pending = 1'b0;
    always @(negedge clk) begin
        if (dbl_pending) begin
            q_model = ~q_model;
            dbl_pending = 1'b0;
        end
        if (rst || rst_prev) begin
            par_a = 1'b0;
            par_b = 1'b0;
        end else begin
            if (a_o != ma) par_a = ~par_a;
            if (b_o != mb) par_b = ~par_b;
            if (clk_o != mc) begin
                if (CHK && par_a == par_b && cell_mode != MODE_NEVER) begin
                    q_model = ~q_model;
                    if (cell_mode == MODE_DOUBLE) dbl_pending = 1'b1;
                end
                par_a = 1'b0;
                par_b = 1'b0;
            end
        end
        ma = a_o; mb = b_o; mc = clk_o; rst_prev = rst;
    end

    // Monitor: times every pulse against the accepting edge and scores responses.
    int e0 = 0, a_t = -1, b_t = -1, clk_t = -1, na = 0, nb = 0, nc = 0;
    int last_clk = -1000, ready_due = -1;
    bit inflight = 1'b0;
    logic pa = 1'b0, pb = 1'b0, pc = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            inflight = 1'b0;
            last_clk = -1000;
            ready_due = -1;
        end else begin
            if (inflight && a_o != pa) begin
                na++; a_t = cyc - e0;
                check("a_after_clk_spacing", (cyc - last_clk >= SEP_CLK_DATA) ? 1 : 0, 1);
            end
            if (inflight && b_o != pb) begin
                nb++; b_t = cyc - e0;
                check("b_after_clk_spacing", (cyc - last_clk >= SEP_CLK_DATA) ? 1 : 0, 1);
            end
            if (inflight && clk_o != pc) begin
                nc++; clk_t = cyc - e0; last_clk = cyc;
            end
            if (ready_due == cyc) begin
                check("ready_after_rsp", int'(req_ready), 1);
                ready_due = -1;
            end
            if (rsp_valid) begin
                if (!inflight || exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("a_edge", a_t, e.a_t);
                    check("b_edge", b_t, e.b_t);
                    check("clk_edge", clk_t, e.clk_t);
                    check("rsp_edge", cyc - e0, e.rsp_t);
                    check("a_pulses", na, (e.a_t >= 0) ? 1 : 0);
                    check("b_pulses", nb, (e.b_t >= 0) ? 1 : 0);
                    check("clk_pulses", nc, 1);
                    check("rsp_q", int'(rsp_q), int'(e.q));
                    check("rsp_error", int'(rsp_error), int'(e.err));
                end
                inflight = 1'b0;
                ready_due = cyc + 1;
            end
            if (req_valid && req_ready) begin
                inflight = 1'b1;
                e0 = cyc + 1;
                a_t = -1; b_t = -1; clk_t = -1; na = 0; nb = 0; nc = 0;
            end
        end
        pa = a_o; pb = b_o; pc = clk_o;
    end

    task automatic wait_accept();
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic a, input logic b, input int mode);
        cell_mode = mode;
        exp_q.push_back(model(a, b, mode));
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        wait_accept();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || !req_ready) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // Counts edges after a reset release until req_ready, checking lines stay quiet.
    task automatic check_init_after_release(input string name);
        int n;
        int quiet;
        n = 0;
        quiet = 1;
        while (!req_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (a_o || b_o || clk_o || rsp_valid) quiet = 0;
        end
        check({name, "_ready_edges"}, n, INIT_CYCLES);
        check({name, "_lines_quiet"}, quiet, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic ra, rb;
        int   rm;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({a_o, b_o, clk_o, rsp_valid, rsp_q, rsp_error, req_ready}), 0);
        rst = 1'b0;
        check_init_after_release("init");

        issue(1'b0, 1'b0, MODE_NORMAL); wait_idle();
        issue(1'b1, 1'b0, MODE_NORMAL); wait_idle();
        issue(1'b0, 1'b1, MODE_NORMAL); wait_idle();
        issue(1'b1, 1'b1, MODE_NORMAL); wait_idle();

        issue(1'b1, 1'b1, MODE_NEVER); wait_idle();

        issue(1'b0, 1'b0, MODE_NORMAL);
        issue(1'b1, 1'b1, MODE_NORMAL);
        wait_idle();

        // Abandon a (1,1) sequence with reset sampled at its third edge.
        cell_mode = MODE_NORMAL;
        req_a = 1'b1; req_b = 1'b1; req_valid = 1'b1;
        wait_accept();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_outputs", int'({a_o, b_o, clk_o, rsp_valid, req_ready}), 0);
        rst = 1'b0;
        check_init_after_release("midreset");
        check("midreset_no_pending", exp_q.size(), 0);

        issue(1'b1, 1'b1, MODE_DOUBLE); wait_idle();
        q_extra = ~q_extra;
        repeat (2) @(posedge clk);
        #1;
        issue(1'b1, 1'b0, MODE_NORMAL); wait_idle();

        for (int i = 0; i < 24; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            rm = $urandom_range(0, 2);
            issue(ra, rb, rm);
            if ($urandom_range(0, 1) == 1) begin
                ra = 1'($urandom_range(0, 1));
                rb = 1'($urandom_range(0, 1));
                issue(ra, rb, rm);
            end
            wait_idle();
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
